alu_rr_share: RTL and testbench
===============================

Name: alu_rr_share

Overview:
- Shares one ALU (`alu`, RV32I op set from `alu_pkg`) among NREQ independent requesters.
- Per-requester valid/ready request ports; round-robin grant, at most one per cycle.
- The granted operands are fed to an internal `alu` instance; the result is captured in a single-entry response register tagged with the requester index.
- Sits between issue slots (e.g. address-gen, branch-compare, execute) and the shared compute unit.

Parameters:
- XLEN, 32, operand/result width; passed to the internal `alu`.
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), width of rsp_id; derived localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ x XLEN  operand A per requester (unpacked array).
- req_b  in  NREQ x XLEN  operand B per requester.
- req_op  in  NREQ x alu_op_e  operation per requester.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that produced the result.
- rsp_y  out  XLEN  ALU result.
- rsp_eq / rsp_lt / rsp_ltu  out  1 each  ALU compare flags for the same operands.
- busy  out  1  rsp_valid OR any req_valid.

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_id=0, rsp_y=0, all flags=0.
  - Round-robin pointer last_gnt=NREQ-1, so requester 0 has top priority after reset.
  - req_ready is forced to 0 while rst=1.
  - Reset mid-transaction discards any held response; no response is emitted for it.
- can_accept = !rsp_valid || rsp_ready (the response slot drains in the same cycle).
- Grant (combinational):
  - If can_accept, gnt is the first i with req_valid[i]=1, scanning from (last_gnt+1) mod NREQ and wrapping.
  - req_ready = gnt (one-hot); all zeros if can_accept=0 or no request is valid.
  - req_ready never depends on rsp_valid alone; it depends on rsp_ready only through can_accept.
- Transfer: requester i completes a transfer when req_valid[i] && req_ready[i] in the same cycle.
- Datapath:
  - The internal ALU inputs are muxed from the granted requester's a/b/op.
  - When nothing is granted the mux selects index 0; the result is not captured.
- Capture (on the transfer edge):
  - Load rsp_y, the three flags and rsp_id from the ALU outputs and the grant index.
  - Set rsp_valid=1 and last_gnt=granted index.
  - Latency: request accepted at edge N, response visible after edge N (rsp_valid=1 during cycle N+1).
- Drain without refill: rsp_valid && rsp_ready with no transfer that cycle clears rsp_valid to 0.
- Drain and refill in the same cycle: the new result overwrites and rsp_valid stays 1. Full throughput is 1 op/cycle when rsp_ready is held at 1.
- Backpressure: rsp_valid && !rsp_ready holds the response fields stable, grants nothing, and leaves last_gnt unchanged.
- Fairness:
  - A continuously valid requester is granted within NREQ accepted transfers.
  - The pointer moves only on a transfer, never on idle or stall cycles.
- Requester obligation (assertion only): while req_valid[i] && !req_ready[i], the requester must not change req_a[i], req_b[i], req_op[i] or deassert req_valid[i].
- Unknown or default op: the ALU returns 0 and the block still transfers and tags normally.
- Assertions:
  - $onehot0(req_ready).
  - rsp_* stable while rsp_valid && !rsp_ready.
  - No transfer while rst.

Test Plan:
- Single request, no contention: reset, then req_valid=4'b0100, a=7, b=5, op=ALU_SUB, rsp_ready=1 -> req_ready=4'b0100 same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_y=2, rsp_lt=0.
- Full contention, round-robin: all four valid and held, rsp_ready=1, op=ALU_ADD with a=i, b=100 -> grant order 0,1,2,3,0 on consecutive cycles; rsp_y=100,101,102,103,100.
- Backpressure: rsp_valid=1 with rsp_ready=0 for 3 cycles, req 1 and 3 valid -> req_ready=0 all 3 cycles, rsp fields frozen, last_gnt unchanged. On release, drain and refill happen in the same cycle and the next grant goes to requester 1 (previous grant was 0).
- Signed compare and shift: a=32'hFFFF_FFFF, b=1, op=ALU_SLT -> rsp_y=1, rsp_lt=1, rsp_ltu=0. Then op=ALU_SRA, a=32'h8000_0000, b=32'h0000_0021 -> rsp_y=32'hC000_0000 (shamt uses b[4:0]=1).
- Reset mid-operation: rsp_valid=1 with rsp_ready=0, assert rst for 1 cycle while req 2 is valid -> rsp_valid=0 and req_ready=0 during reset. The first grant after reset goes to requester 0 if valid, otherwise to 2.
- Random soak, 10k cycles: random req_valid and rsp_ready, scoreboard against a reference ALU model -> every accepted request produces exactly one response, in acceptance order, with the correct rsp_id and rsp_y. Max wait per requester is at most NREQ transfers.

Source files
------------

// File: rtl/alu_rr_share.sv
// One RV32I-style ALU shared by NREQ requesters through a round-robin grant.
// Each result lands in a single-entry response register tagged with the requester index.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_e         i_op,
  output logic [XLEN-1:0] o_y,
  output logic            o_eq,
  output logic            o_lt,
  output logic            o_ltu
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;

  assign w_shamt = i_b[SHW-1:0];
  assign o_eq    = (i_a == i_b);
  assign o_lt    = ($signed(i_a) < $signed(i_b));
  assign o_ltu   = (i_a < i_b);

  // Encodings outside the defined op set yield zero.
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, o_lt};
      ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, o_ltu};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_SRA:  o_y = $signed(i_a) >>> w_shamt;
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      default:  o_y = '0;
    endcase
  end
endmodule

module alu_rr_share
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [XLEN-1:0] req_a [NREQ],
  input  logic [XLEN-1:0] req_b [NREQ],
  input  alu_op_e         req_op [NREQ],
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [XLEN-1:0] rsp_y,
  output logic            rsp_eq,
  output logic            rsp_lt,
  output logic            rsp_ltu,
  output logic            busy
);
  // Handshake: a beat moves on a rising edge where valid && ready are both 1.
  // req_ready never waits on req_valid of another port beyond arbitration, and
  // a requester holding valid without ready must keep its payload stable.
  // The response slot accepts a new result whenever it is empty or draining.

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [XLEN-1:0] r_rsp_y;
  logic            r_rsp_eq;
  logic            r_rsp_lt;
  logic            r_rsp_ltu;
  logic [IDW-1:0]  r_last_gnt;

  logic            w_can_accept;
  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_fire;
  logic [IDW-1:0]  w_sel;
  int              w_scan;
  logic [IDW-1:0]  w_scan_idx;
  logic [XLEN-1:0] w_alu_y;
  logic            w_alu_eq;
  logic            w_alu_lt;
  logic            w_alu_ltu;

  assign w_can_accept = !r_rsp_valid || rsp_ready;

  // Scan starts one past the last granted index and wraps.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = 0;
    w_scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_scan     = (int'(r_last_gnt) + k) % NREQ;
      w_scan_idx = IDW'(w_scan);
      if (!w_gnt_found && req_valid[w_scan_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan_idx;
      end
    end
  end

  assign w_fire = w_can_accept && w_gnt_found && !rst;

  always_comb begin
    req_ready = '0;
    if (w_fire) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_sel = w_fire ? w_gnt_idx : '0;

  alu #(.XLEN(XLEN)) u_alu (
    .i_a   (req_a[w_sel]),
    .i_b   (req_b[w_sel]),
    .i_op  (req_op[w_sel]),
    .o_y   (w_alu_y),
    .o_eq  (w_alu_eq),
    .o_lt  (w_alu_lt),
    .o_ltu (w_alu_ltu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_rsp_eq    <= 1'b0;
      r_rsp_lt    <= 1'b0;
      r_rsp_ltu   <= 1'b0;
      r_last_gnt  <= IDW'(NREQ - 1);
    end else if (w_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_y     <= w_alu_y;
      r_rsp_eq    <= w_alu_eq;
      r_rsp_lt    <= w_alu_lt;
      r_rsp_ltu   <= w_alu_ltu;
      r_last_gnt  <= w_gnt_idx;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_eq    = r_rsp_eq;
  assign rsp_lt    = r_rsp_lt;
  assign rsp_ltu   = r_rsp_ltu;
  assign busy      = r_rsp_valid || (|req_valid);

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

  a_no_xfer_in_rst: assert property (@(posedge clk) rst |-> (req_ready == '0));

  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_y)
      && $stable(rsp_eq) && $stable(rsp_lt) && $stable(rsp_ltu)));

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[gi] && !req_ready[gi]) |=> (req_valid[gi] && $stable(req_a[gi])
        && $stable(req_b[gi]) && $stable(req_op[gi])));
  end
endmodule

// File: tb/tb_alu_rr_share.sv
// Bench for alu_rr_share: directed scenarios plus a randomized soak checked
// against a plain-arithmetic ALU model and a round-robin grant model.
module tb_alu_rr_share;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int RW   = IDW + 3 + XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [XLEN-1:0] req_a [NREQ];
  logic [XLEN-1:0] req_b [NREQ];
  alu_op_e         req_op [NREQ];
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [XLEN-1:0] rsp_y;
  logic            rsp_eq;
  logic            rsp_lt;
  logic            rsp_ltu;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  alu_rr_share #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .rsp_ltu   (rsp_ltu),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i]  = '0;
      req_b[i]  = '0;
      req_op[i] = ALU_ADD;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Returns {eq, lt, ltu, y} for the operands.
  function automatic logic [XLEN+2:0] ref_alu(alu_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    logic [XLEN-1:0] y;
    logic [XLEN-1:0] ones;
    int sh;
    ones = '1;
    sh = int'(b[4:0]);
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: y = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = (a >> sh) | (a[XLEN-1] ? ~(ones >> sh) : 32'd0);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = 32'd0;
    endcase
    return {(a == b), ($signed(a) < $signed(b)), (a < b), y};
  endfunction

  function automatic logic [XLEN-1:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return 32'($urandom());
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_eq, rsp_lt, rsp_ltu} !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%0d y=%h flags=%b%b%b expected all 0",
                         rsp_valid, rsp_id, rsp_y, rsp_eq, rsp_lt, rsp_ltu);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_a[2] = 32'd7; req_b[2] = 32'd5; req_op[2] = ALU_SUB;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 32'd2 || rsp_lt !== 1'b0) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%0d y=%h lt=%b expected v=1 id=2 y=2 lt=0",
                         rsp_valid, rsp_id, rsp_y, rsp_lt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 32'(i); req_b[i] = 32'd100; req_op[i] = ALU_ADD;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (k % NREQ))) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, 4'(1 << (k % NREQ)));
      end
      if (k > 0) begin
        checks++;
        if (rsp_id !== 2'((k - 1) % NREQ) || rsp_y !== 32'(100 + (k - 1) % NREQ)) begin
          errors++; $display("FAIL rr_rsp[%0d]: got id=%0d y=%0d expected id=%0d y=%0d",
                             k, rsp_id, rsp_y, (k - 1) % NREQ, 100 + (k - 1) % NREQ);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001;
    req_a[0] = 32'd1; req_b[0] = 32'd2; req_op[0] = ALU_ADD;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_first: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = 4'b1010;
    req_a[1] = 32'd10; req_b[1] = 32'd20; req_op[1] = ALU_ADD;
    req_a[3] = 32'd30; req_b[3] = 32'd40; req_op[3] = ALU_ADD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_y !== 32'd3) begin
        errors++; $display("FAIL bp_stall[%0d]: got ready=%b v=%b id=%0d y=%0d expected 0000 1 0 3",
                           c, req_ready, rsp_valid, rsp_id, rsp_y);
      end
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_release: got ready=%b v=%b expected 0010 1", req_ready, rsp_valid);
    end
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 32'd30) begin
      errors++; $display("FAIL bp_refill: got ready=%b v=%b id=%0d y=%0d expected 1000 1 1 30",
                         req_ready, rsp_valid, rsp_id, rsp_y);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 32'd70) begin
      errors++; $display("FAIL bp_last: got v=%b id=%0d y=%0d expected 1 3 70", rsp_valid, rsp_id, rsp_y);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_compare_shift();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1; req_op[0] = ALU_SLT;
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_y !== 32'd1 || rsp_lt !== 1'b1 || rsp_ltu !== 1'b0 || rsp_eq !== 1'b0) begin
      errors++; $display("FAIL slt: got y=%h eq=%b lt=%b ltu=%b expected 1 0 1 0", rsp_y, rsp_eq, rsp_lt, rsp_ltu);
    end
    tick();
    req_valid = 4'b0001;
    req_a[0] = 32'h8000_0000; req_b[0] = 32'h0000_0021; req_op[0] = ALU_SRA;
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_y !== 32'hC000_0000 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL sra: got y=%h id=%0d expected C0000000 0", rsp_y, rsp_id);
    end
    tick();
    req_valid = 4'b1000;
    req_a[3] = 32'd5; req_b[3] = 32'd6; req_op[3] = alu_op_e'(4'hF);
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 32'd0 || rsp_lt !== 1'b1 || rsp_ltu !== 1'b1) begin
      errors++; $display("FAIL bad_op: got v=%b id=%0d y=%h lt=%b ltu=%b expected 1 3 0 1 1",
                         rsp_valid, rsp_id, rsp_y, rsp_lt, rsp_ltu);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_a[0] = 32'd50; req_b[0] = 32'd60; req_op[0] = ALU_ADD;
    tick();
    req_valid = 4'b0100;
    req_a[2] = 32'd9; req_b[2] = 32'd4; req_op[2] = ALU_OR;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rmid_held: got v=%b ready=%b expected 1 0000", rsp_valid, req_ready);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL rmid_ready_in_rst: got %b expected 0000", req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rmid_cleared: got v=%b ready=%b expected 0 0000", rsp_valid, req_ready);
    end
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = ALU_ADD;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_first: got ready=%b v=%b expected 0001 0", req_ready, rsp_valid);
    end
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || rsp_id !== 2'd0 || rsp_y !== 32'd2) begin
      errors++; $display("FAIL rmid_second: got ready=%b id=%0d y=%0d expected 0100 0 2", req_ready, rsp_id, rsp_y);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd2 || rsp_y !== 32'd13) begin
      errors++; $display("FAIL rmid_third: got id=%0d y=%0d expected 2 13", rsp_id, rsp_y);
    end
  endtask

  task automatic test_soak();
    int m_last;
    int gnt;
    int idx;
    bit pend [NREQ];
    int wait_cnt [NREQ];
    logic [NREQ-1:0] exp_ready;
    logic [RW-1:0] front;
    logic [RW-1:0] got;
    do_reset();
    m_last = NREQ - 1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      wait_cnt[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_valid[i] = 1'b1;
            req_a[i] = rand_operand();
            req_b[i] = rand_operand();
            req_op[i] = alu_op_e'(4'($urandom_range(0, 15)));
            pend[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (rsp_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL soak_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, exp_q.size() != 0);
      end
      exp_ready = '0;
      gnt = -1;
      if (exp_q.size() == 0 || rsp_ready) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (gnt < 0 && req_valid[idx]) gnt = idx;
        end
      end
      if (gnt >= 0) exp_ready[gnt] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL soak_grant[%0d]: got %b expected %b", c, req_ready, exp_ready);
      end
      if (exp_q.size() != 0 && rsp_ready) begin
        front = exp_q.pop_front();
        got = {rsp_id, rsp_eq, rsp_lt, rsp_ltu, rsp_y};
        checks++;
        if (got !== front) begin
          errors++; $display("FAIL soak_rsp[%0d]: got id/flags/y=%h expected %h", c, got, front);
        end
      end
      if (gnt >= 0) begin
        for (int i = 0; i < NREQ; i++)
          if (i != gnt && req_valid[i]) wait_cnt[i]++;
        checks++;
        if (wait_cnt[gnt] > NREQ - 1) begin
          errors++; $display("FAIL soak_fair[%0d]: requester %0d waited %0d transfers, limit %0d",
                             c, gnt, wait_cnt[gnt], NREQ - 1);
        end
        wait_cnt[gnt] = 0;
        pend[gnt] = 1'b0;
        exp_q.push_back({IDW'(gnt), ref_alu(req_op[gnt], req_a[gnt], req_b[gnt])});
        m_last = gnt;
      end
      tick();
    end
    do_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_compare_shift();
    test_reset_mid();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
